alu_issue_ctrl: RTL and testbench

- Issue/writeback controller placed in front of the 4-bit combinational ALU.
- Accepts instructions over a valid/ready handshake and reads operands from a small internal register file.
- Drives the ALU opcode and operand inputs from registers, captures the ALU result, writes it back, and presents it on a valid/ready result port.
- Acts as both the producer of ALU stimulus and the consumer of ALU output.

---
 rtl/alu_issue_ctrl_pkg.sv | 21 ++
 rtl/alu_issue_ctrl_regfile.sv | 38 +++
 rtl/alu_issue_ctrl.sv | 121 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue/writeback controller: FSM states,
// default datapath widths and the opcodes understood by the 4-bit ALU.
package alu_issue_ctrl_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_OP_W   = 3;
    localparam int DEF_REG_AW = 2;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [DEF_OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [DEF_OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [DEF_OP_W-1:0] OP_AND = 3'b010;
    localparam logic [DEF_OP_W-1:0] OP_OR  = 3'b011;

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// Small register file: two combinational operand read ports, one debug read
// port, one synchronous write port, synchronously cleared by rst.
module alu_regfile
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rd_addr_1,
    output logic [DATA_W-1:0] rd_data_1,
    input  logic [REG_AW-1:0] rd_addr_2,
    output logic [DATA_W-1:0] rd_data_2,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [2**REG_AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**REG_AW; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_1 = mem[rd_addr_1];
    assign rd_data_2 = mem[rd_addr_2];
    assign dbg_data  = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller in front of a combinational ALU: registers the
// ALU inputs, captures its result a cycle later and hands it out on res_*.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OP_W   = DEF_OP_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   instr_op,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_rs1,
    input  logic [REG_AW-1:0] instr_rs2,
    input  logic              instr_imm_sel,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_operand_1,
    output logic [DATA_W-1:0] alu_operand_2,
    input  logic [DATA_W-1:0] alu_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [REG_AW-1:0] res_rd,
    output logic [CNT_W-1:0]  instr_count,
    input  logic [REG_AW-1:0] rf_dbg_addr,
    output logic [DATA_W-1:0] rf_dbg_data
);

    state_t            state;
    state_t            state_next;
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              accept;
    logic              retire;

    alu_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_1 (instr_rs1),
        .rd_data_1 (rs1_data),
        .rd_addr_2 (instr_rs2),
        .rd_data_2 (rs2_data),
        .dbg_addr  (rf_dbg_addr),
        .dbg_data  (rf_dbg_data),
        .wr_en     (state == EXEC),
        .wr_addr   (rd_q),
        .wr_data   (alu_result)
    );

    // Retiring in WB frees the slot, so a waiting instruction is taken in the same edge.
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        retire      = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = WB;
            end
            WB: begin
                if (res_ready) begin
                    retire      = 1'b1;
                    instr_ready = 1'b1;
                    state_next  = instr_valid ? EXEC : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (rst) begin
            instr_ready = 1'b0;
        end
    end

    assign accept    = instr_valid && instr_ready;
    assign res_valid = (state == WB);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rd_q          <= '0;
            alu_opcode    <= '0;
            alu_operand_1 <= '0;
            alu_operand_2 <= '0;
            res_data      <= '0;
            res_rd        <= '0;
            instr_count   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                alu_opcode    <= instr_op;
                alu_operand_1 <= rs1_data;
                alu_operand_2 <= instr_imm_sel ? instr_imm : rs2_data;
                rd_q          <= instr_rd;
            end
            if (state == EXEC) begin
                res_data <= alu_result;
                res_rd   <= rd_q;
            end
            if (retire) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios then random
// instructions, compared against a register-file/counter reference model.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    localparam int DATA_W = 4;
    localparam int OP_W   = 3;
    localparam int REG_AW = 2;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst;
    logic              instr_valid;
    logic              instr_ready;
    logic [OP_W-1:0]   instr_op;
    logic [REG_AW-1:0] instr_rd;
    logic [REG_AW-1:0] instr_rs1;
    logic [REG_AW-1:0] instr_rs2;
    logic              instr_imm_sel;
    logic [DATA_W-1:0] instr_imm;
    logic [OP_W-1:0]   alu_opcode;
    logic [DATA_W-1:0] alu_operand_1;
    logic [DATA_W-1:0] alu_operand_2;
    logic [DATA_W-1:0] alu_result;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [REG_AW-1:0] res_rd;
    logic [CNT_W-1:0]  instr_count;
    logic [REG_AW-1:0] rf_dbg_addr;
    logic [DATA_W-1:0] rf_dbg_data;

    int checks;
    int failures;
    int model_rf [4];
    int model_count;
    int last_res;

    alu_issue_ctrl #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W),
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_op      (instr_op),
        .instr_rd      (instr_rd),
        .instr_rs1     (instr_rs1),
        .instr_rs2     (instr_rs2),
        .instr_imm_sel (instr_imm_sel),
        .instr_imm     (instr_imm),
        .alu_opcode    (alu_opcode),
        .alu_operand_1 (alu_operand_1),
        .alu_operand_2 (alu_operand_2),
        .alu_result    (alu_result),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_rd        (res_rd),
        .instr_count   (instr_count),
        .rf_dbg_addr   (rf_dbg_addr),
        .rf_dbg_data   (rf_dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU stub; opcode 100 and above are treated as xor.
    always_comb begin
        case (alu_opcode)
            OP_ADD:  alu_result = alu_operand_1 + alu_operand_2;
            OP_SUB:  alu_result = alu_operand_1 - alu_operand_2;
            OP_AND:  alu_result = alu_operand_1 & alu_operand_2;
            OP_OR:   alu_result = alu_operand_1 | alu_operand_2;
            default: alu_result = alu_operand_1 ^ alu_operand_2;
        endcase
    end

    function automatic int alu_ref(input int op, input int a, input int b);
        case (op)
            0:       return (a + b) % 16;
            1:       return (a - b + 16) % 16;
            2:       return a & b;
            3:       return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkRfAll();
        for (int i = 0; i < 4; i++) begin
            rf_dbg_addr = 2'(i);
            #1;
            checkOutput("rf_entry", 32'(rf_dbg_data), 32'(model_rf[i]));
        end
    endtask

    task automatic applyReset();
        rst         = 1'b1;
        instr_valid = 1'b0;
        res_ready   = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready_in_reset", 32'(instr_ready), 32'd0);
        checkOutput("valid_in_reset", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) model_rf[i] = 0;
        model_count = 0;
        #1;
        checkOutput("reset_count", 32'(instr_count), 32'd0);
        checkOutput("reset_opcode", 32'(alu_opcode), 32'd0);
        checkOutput("reset_op1", 32'(alu_operand_1), 32'd0);
        checkOutput("reset_op2", 32'(alu_operand_2), 32'd0);
        checkOutput("reset_res_data", 32'(res_data), 32'd0);
        checkOutput("reset_res_rd", 32'(res_rd), 32'd0);
        checkOutput("reset_ready", 32'(instr_ready), 32'd1);
        checkRfAll();
    endtask

    // Issues one instruction and leaves the DUT in WB with res_ready low.
    task automatic applyStimulus(input int op, input int rd, input int rs1, input int rs2,
                                 input int sel, input int imm, input bit from_wb);
        int a;
        int b;
        int r;
        a = model_rf[rs1];
        b = (sel != 0) ? imm : model_rf[rs2];
        r = alu_ref(op, a, b);
        instr_op      = 3'(op);
        instr_rd      = 2'(rd);
        instr_rs1     = 2'(rs1);
        instr_rs2     = 2'(rs2);
        instr_imm_sel = (sel != 0);
        instr_imm     = 4'(imm);
        instr_valid   = 1'b1;
        res_ready     = from_wb;
        #1;
        checkOutput("ready_at_accept", 32'(instr_ready), 32'd1);
        @(posedge clk);
        if (from_wb) model_count = (model_count + 1) % 256;
        #1;
        instr_valid = 1'b0;
        res_ready   = 1'b0;
        checkOutput("exec_opcode", 32'(alu_opcode), 32'(op));
        checkOutput("exec_op1", 32'(alu_operand_1), 32'(a));
        checkOutput("exec_op2", 32'(alu_operand_2), 32'(b));
        checkOutput("exec_res_valid", 32'(res_valid), 32'd0);
        checkOutput("exec_ready", 32'(instr_ready), 32'd0);
        checkOutput("exec_count", 32'(instr_count), 32'(model_count));
        @(posedge clk);
        model_rf[rd] = r;
        last_res     = r;
        #1;
        checkOutput("wb_res_valid", 32'(res_valid), 32'd1);
        checkOutput("wb_res_data", 32'(res_data), 32'(r));
        checkOutput("wb_res_rd", 32'(res_rd), 32'(rd));
        checkOutput("wb_ready_stalled", 32'(instr_ready), 32'd0);
        rf_dbg_addr = 2'(rd);
        #1;
        checkOutput("wb_rf_write", 32'(rf_dbg_data), 32'(r));
    endtask

    task automatic stallWb(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            checkOutput("stall_res_valid", 32'(res_valid), 32'd1);
            checkOutput("stall_res_data", 32'(res_data), 32'(last_res));
            checkOutput("stall_ready", 32'(instr_ready), 32'd0);
        end
    endtask

    task automatic retireToIdle();
        res_ready = 1'b1;
        #1;
        checkOutput("retire_ready", 32'(instr_ready), 32'd1);
        @(posedge clk);
        model_count = (model_count + 1) % 256;
        #1;
        res_ready = 1'b0;
        checkOutput("idle_res_valid", 32'(res_valid), 32'd0);
        checkOutput("idle_ready", 32'(instr_ready), 32'd1);
        checkOutput("idle_count", 32'(instr_count), 32'(model_count));
    endtask

    initial begin
        bit in_wb;
        checks        = 0;
        failures      = 0;
        last_res      = 0;
        rst           = 1'b1;
        instr_valid   = 1'b0;
        instr_op      = '0;
        instr_rd      = '0;
        instr_rs1     = '0;
        instr_rs2     = '0;
        instr_imm_sel = 1'b0;
        instr_imm     = '0;
        res_ready     = 1'b0;
        rf_dbg_addr   = '0;
        applyReset();

        applyStimulus(int'(OP_OR), 1, 0, 0, 1, 3, 1'b0);
        retireToIdle();
        applyStimulus(int'(OP_OR), 2, 0, 0, 1, 1, 1'b0);
        retireToIdle();
        checkOutput("count_after_loads", 32'(instr_count), 32'd2);

        applyStimulus(int'(OP_ADD), 3, 1, 2, 0, 0, 1'b0);
        checkOutput("add_result", 32'(res_data), 32'd4);
        retireToIdle();

        applyStimulus(int'(OP_SUB), 0, 2, 1, 0, 0, 1'b0);
        checkOutput("sub_wrap_result", 32'(res_data), 32'd14);
        stallWb(5);
        applyStimulus(int'(OP_ADD), 2, 0, 3, 0, 0, 1'b1);
        checkOutput("b2b_raw_result", 32'(res_data), 32'd2);
        retireToIdle();

        // Abort an instruction in EXEC with reset; nothing may be written back.
        instr_op      = OP_OR;
        instr_rd      = 2'd1;
        instr_rs1     = 2'd0;
        instr_imm_sel = 1'b1;
        instr_imm     = 4'd9;
        instr_valid   = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) model_rf[i] = 0;
        model_count = 0;
        #1;
        checkOutput("abort_res_valid", 32'(res_valid), 32'd0);
        checkOutput("abort_ready", 32'(instr_ready), 32'd1);
        checkOutput("abort_count", 32'(instr_count), 32'd0);
        checkRfAll();
        @(posedge clk);
        #1;
        checkOutput("abort_no_late_valid", 32'(res_valid), 32'd0);

        in_wb = 1'b0;
        for (int i = 0; i < 256; i++) begin
            applyStimulus($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 15), in_wb);
            stallWb($urandom_range(0, 2));
            if (i == 255 || $urandom_range(0, 1) == 0) begin
                retireToIdle();
                in_wb = 1'b0;
            end else begin
                in_wb = 1'b1;
            end
        end
        checkOutput("count_wrap", 32'(instr_count), 32'd0);
        checkRfAll();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
